button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 98 +++++++++
 tb/tb_button_conditioner.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// ============================================================================
//  Module      : button_conditioner
//  Description : Four-channel push-button front end. Each raw, asynchronous
//                input is synchronised, debounced and turned into a single-
//                cycle press pulse on its rising debounced edge (qualified by
//                En). S carries the start pulse; In carries {red,blue,green}.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_conditioner #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnS,
  input  logic       BtnR,
  input  logic       BtnB,
  input  logic       BtnG,
  input  logic       En,
  output logic       S,
  output logic [2:0] In,
  output logic [3:0] Level
);

  // Counter only ever reaches DB_CYCLES-1, so clog2 bits suffice (DB_CYCLES >= 2).
  localparam int unsigned         c_CNT_W   = $clog2(DB_CYCLES);
  localparam logic [c_CNT_W-1:0]  c_CNT_MAX = c_CNT_W'(DB_CYCLES - 1);

  // Channel order matches Level: bit 3 = start, 2 = red, 1 = blue, 0 = green.
  logic [3:0] raw_w;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] pulse_w;

  assign raw_w = {BtnS, BtnR, BtnB, BtnG};

  // Two-flop synchroniser for every raw button before any other logic.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    logic               lvl_q;
    logic               lvl_d;
    logic               prev_q;
    logic               pls_q;
    logic               pls_d;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    // Debounce: count consecutive disagreeing cycles, flip the level on the
    // DB_CYCLES-th one; any agreeing cycle restarts the count. The press
    // pulse is the registered rising edge of the level, gated by En.
    always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      if (sync2_q[gi] != lvl_q) begin
        if (cnt_q == c_CNT_MAX) begin
          lvl_d = ~lvl_q;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      pls_d = lvl_q & ~prev_q & En;
    end

    // Channel state; prev_q delays the level one cycle for edge detection.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        lvl_q  <= 1'b0;
        prev_q <= 1'b0;
        pls_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        lvl_q  <= lvl_d;
        prev_q <= lvl_q;
        pls_q  <= pls_d;
        cnt_q  <= cnt_d;
      end
    end

    assign Level[gi]   = lvl_q;
    assign pulse_w[gi] = pls_q;
  end

  assign S  = pulse_w[3];
  assign In = pulse_w[2:0];

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed, table-driven bench for button_conditioner with
//                DB_CYCLES = 4 (level rises at edge 6, pulse after edge 7).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  localparam int unsigned DB = 4;

  // Masks in {S,R,B,G} order.
  localparam logic [3:0] M_S = 4'b1000;
  localparam logic [3:0] M_R = 4'b0100;
  localparam logic [3:0] M_B = 4'b0010;
  localparam logic [3:0] M_G = 4'b0001;
  localparam logic [3:0] NONE = 4'b0000;

  typedef struct {
    logic [3:0] btn;
    logic       en;
    logic       rst;
    logic [3:0] exp_pls;   // {S, In}
    logic [3:0] exp_lvl;
    string      name;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       BtnS = 1'b0;
  logic       BtnR = 1'b0;
  logic       BtnB = 1'b0;
  logic       BtnG = 1'b0;
  logic       En = 1'b1;
  logic       S;
  logic [2:0] In;
  logic [3:0] Level;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  button_conditioner #(.DB_CYCLES(DB)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .BtnS  (BtnS),
    .BtnR  (BtnR),
    .BtnB  (BtnB),
    .BtnG  (BtnG),
    .En    (En),
    .S     (S),
    .In    (In),
    .Level (Level)
  );

  always #5 Clk = ~Clk;

  task automatic add(input logic [3:0] btn, input logic en, input logic rst,
                     input logic [3:0] pls, input logic [3:0] lvl, input string nm);
    vec_t v;
    v.btn = btn; v.en = en; v.rst = rst;
    v.exp_pls = pls; v.exp_lvl = lvl; v.name = nm;
    tbl.push_back(v);
  endtask

  // Clean press from a quiet channel: level up at edge 6, pulse after edge 7;
  // release mirrors it with level down at release edge 6 and no pulse.
  task automatic add_press(input logic [3:0] mask, input int hold, input int rel,
                           input string nm);
    for (int k = 1; k <= hold; k++)
      add(mask, 1'b1, 1'b0, (k == DB + 3) ? mask : NONE, (k >= DB + 2) ? mask : NONE, nm);
    for (int k = 1; k <= rel; k++)
      add(NONE, 1'b1, 1'b0, NONE, (k >= DB + 2) ? NONE : mask, {nm, "_rel"});
  endtask

  // One cycle: drive, clock, sample 1 time unit after the edge, compare.
  task automatic step(input logic [3:0] btn, input logic en, input logic rst,
                      input logic [3:0] pls, input logic [3:0] lvl, input string nm);
    {BtnS, BtnR, BtnB, BtnG} = btn;
    En    = en;
    Reset = rst;
    @(posedge Clk);
    #1;
    n_vec++;
    if ({S, In} !== pls || Level !== lvl) begin
      n_bad++;
      $display("FAIL %s vec %0d: got S=%b In=%b Level=%b, want S=%b In=%b Level=%b",
               nm, n_vec, S, In, Level, pls[3], pls[2:0], lvl);
    end
  endtask

  initial begin
    // ---------------- table fill ----------------
    add(4'hF, 1'b1, 1'b1, NONE, NONE, "reset_btn_high");
    add(NONE, 1'b1, 1'b1, NONE, NONE, "reset");
    add(NONE, 1'b1, 1'b0, NONE, NONE, "idle");
    add(NONE, 1'b0, 1'b0, NONE, NONE, "idle_en0");
    add_press(M_R, 20, 10, "red_hold20");
    add_press(M_R | M_G, 10, 8, "red_green");
    add_press(M_S, 10, 8, "start");
    for (int p = 0; p < 3; p++) add_press(M_G, 8, 8, "green_x3");
    // Three-cycle glitches never reach the fourth disagreeing cycle.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) add(M_B, 1'b1, 1'b0, NONE, NONE, "blue_glitch");
      add(NONE, 1'b1, 1'b0, NONE, NONE, "blue_glitch_gap");
    end
    for (int k = 0; k < 6; k++) add(NONE, 1'b1, 1'b0, NONE, NONE, "glitch_idle");
    // Exactly four raw-high cycles: level up edges 6..9, pulse after edge 7.
    for (int k = 1; k <= 14; k++)
      add((k <= 4) ? M_B : NONE, 1'b1, 1'b0, (k == 7) ? M_B : NONE,
          (k >= 6 && k <= 9) ? M_B : NONE, "blue_min_width");

    // ---------------- table apply ----------------
    foreach (tbl[i])
      step(tbl[i].btn, tbl[i].en, tbl[i].rst, tbl[i].exp_pls, tbl[i].exp_lvl, tbl[i].name);

    // En low during the whole press, then raised while still held: no pulse.
    for (int k = 1; k <= 14; k++)
      step(M_B, (k >= 10) ? 1'b1 : 1'b0, 1'b0, NONE, (k >= 6) ? M_B : NONE, "blue_en0");
    for (int k = 1; k <= 8; k++)
      step(NONE, 1'b1, 1'b0, NONE, (k >= 6) ? NONE : M_B, "blue_en0_rel");

    // En low only at the edge the pulse would register: dropped, not deferred.
    for (int k = 1; k <= 10; k++)
      step(M_G, (k == 7) ? 1'b0 : 1'b1, 1'b0, NONE, (k >= 6) ? M_G : NONE, "green_en_drop");
    for (int k = 1; k <= 8; k++)
      step(NONE, 1'b1, 1'b0, NONE, (k >= 6) ? NONE : M_G, "green_en_drop_rel");

    // Reset at counter==2 (after edge 4) with red held: fresh press afterwards.
    for (int k = 1; k <= 4; k++)
      step(M_R, 1'b1, 1'b0, NONE, NONE, "red_pre_reset");
    step(M_R, 1'b1, 1'b1, NONE, NONE, "red_reset_edge");
    for (int k = 1; k <= 10; k++)
      step(M_R, 1'b1, 1'b0, (k == 7) ? M_R : NONE, (k >= 6) ? M_R : NONE, "red_post_reset");
    for (int k = 1; k <= 8; k++)
      step(NONE, 1'b1, 1'b0, NONE, (k >= 6) ? NONE : M_R, "red_post_reset_rel");

    // Reset while the pulse is high aborts it; released button stays quiet.
    for (int k = 1; k <= 7; k++)
      step(M_G, 1'b1, 1'b0, (k == 7) ? M_G : NONE, (k >= 6) ? M_G : NONE, "green_pre_reset");
    step(NONE, 1'b1, 1'b1, NONE, NONE, "green_reset_mid_pulse");
    for (int k = 1; k <= 6; k++)
      step(NONE, 1'b1, 1'b0, NONE, NONE, "green_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
